// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the 4-way mux arbiter.
// Used by the arbiter top, its interface and the picker.
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] id2onehot(
    input logic [ID_W-1:0] id
  );
    logic [N_REQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/arbiter bundle for mux4_rr_arbiter.
// MUX_ARB_LOCK_EN adds the owner lock input.
interface mux4_rr_arbiter_if;
  import mux_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic             s0;
  logic             s1;
  logic             busy;
  logic             out_vld;
  logic [ID_W-1:0]  out_id;
`ifdef MUX_ARB_LOCK_EN
  logic             lock;

  modport master (
    output req, lock,
    input  gnt, s0, s1, busy, out_vld, out_id
  );
  modport slave (
    input  req, lock,
    output gnt, s0, s1, busy, out_vld, out_id
  );
`else
  modport master (
    output req,
    input  gnt, s0, s1, busy, out_vld, out_id
  );
  modport slave (
    input  req,
    output gnt, s0, s1, busy, out_vld, out_id
  );
`endif

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Rotating-priority picker: first set request from ptr_i upward,
// optionally skipping one excluded requester.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  input  logic             excl_en_i,
  input  logic [ID_W-1:0]  excl_id_i,
  output logic             found_o,
  output logic [ID_W-1:0]  id_o
);

  logic [N_REQ-1:0] cand;

  assign cand = req_i
              & ~(excl_en_i ? id2onehot(excl_id_i) : '0);

  // Scan farthest-first so the nearest hit wins.
  always_comb begin
    found_o = 1'b0;
    id_o    = ptr_i;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (cand[ptr_i + ID_W'(k)]) begin
        found_o = 1'b1;
        id_o    = ptr_i + ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a pipelined 4:1 mux select with ID tags.
// Define MUX_ARB_LOCK_EN to let a locked owner outlast HOLD_MAX.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int MUX_LAT  = 2,
  parameter int CNT_W    = 8
) (
  input logic              clk,
  input logic              rst_n,
  mux4_rr_arbiter_if.slave bus
);

  state_e           state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [ID_W-1:0]  sel_q;
  logic [ID_W-1:0]  owner_q;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [CNT_W-1:0] hold_q;
  logic             busy_q;
  logic [ID_W:0]    tag_q [MUX_LAT];

  logic [N_REQ-1:0] own_oh;
  logic             own_req;
  logic             others;
  logic             hold_end;
  logic             lock_hold;
  logic             expire;
  logic             rel;
  logic             in_grant;
  logic [ID_W-1:0]  pick_ptr;
  logic [ID_W-1:0]  pick_id;
  logic             found;

  assign in_grant = (state_q == ST_GRANT);
  assign own_oh   = id2onehot(owner_q);
  assign own_req  = |(bus.req & own_oh);
  assign others   = |(bus.req & ~own_oh);
  assign hold_end = (hold_q == CNT_W'(HOLD_MAX - 1));
`ifdef MUX_ARB_LOCK_EN
  assign lock_hold = own_req & bus.lock;
`else
  assign lock_hold = 1'b0;
`endif
  assign expire   = hold_end & others & ~lock_hold;
  assign rel      = ~own_req | expire;
  assign pick_ptr = in_grant ? owner_q + 2'd1 : rr_ptr_q;

  rr_pick4 u_pick (
    .req_i     (bus.req),
    .ptr_i     (pick_ptr),
    .excl_en_i (in_grant),
    .excl_id_i (owner_q),
    .found_o   (found),
    .id_o      (pick_id)
  );

  assign bus.gnt     = gnt_q;
  assign bus.s0      = sel_q[1];
  assign bus.s1      = sel_q[0];
  assign bus.busy    = busy_q;
  assign bus.out_vld = tag_q[MUX_LAT-1][ID_W];
  assign bus.out_id  = tag_q[MUX_LAT-1][ID_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      sel_q    <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      hold_q   <= '0;
      busy_q   <= 1'b0;
      for (int i = 0; i < MUX_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      // Tags trail the registered select by MUX_LAT.
      tag_q[0] <= {|gnt_q, owner_q};
      for (int i = 1; i < MUX_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      unique case (state_q)
        ST_IDLE: begin
          if (found) begin
            gnt_q   <= id2onehot(pick_id);
            sel_q   <= pick_id;
            owner_q <= pick_id;
            hold_q  <= '0;
            state_q <= ST_GRANT;
            busy_q  <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (rel) begin
            rr_ptr_q <= owner_q + 2'd1;
            if (found) begin
              gnt_q   <= id2onehot(pick_id);
              sel_q   <= pick_id;
              owner_q <= pick_id;
              hold_q  <= '0;
            end else begin
              gnt_q   <= '0;
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else if (hold_end) begin
            if (!lock_hold) hold_q <= '0;
          end else begin
            hold_q <= hold_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Random + directed bench for mux4_rr_arbiter against a
// cycle-count reference model.
module tb_mux4_rr_arbiter;
  import mux_arb_pkg::*;

  localparam int HOLD_MAX = 8;
  localparam int MUX_LAT  = 2;
  localparam int CNT_W    = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter #(
    .HOLD_MAX (HOLD_MAX),
    .MUX_LAT  (MUX_LAT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: owner (-1 = none), cycles held so far,
  // next priority start, last select, tag history.
  int       m_own;
  int       m_run;
  int       m_ptr;
  int       m_sel;
  bit [2:0] m_pipe [$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input bit [3:0] r,
                              input int ptr,
                              input int excl);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (ptr + k) % 4;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_own = -1;
    m_run = 0;
    m_ptr = 0;
    m_sel = 0;
    m_pipe.delete();
    repeat (MUX_LAT) m_pipe.push_back(3'b0);
  endtask

  task automatic model_edge(input bit [3:0] r, input bit l);
    int  w;
    bit  mine;
    bit  oth;
    bit  lh;
    m_pipe.push_back(m_own >= 0 ? {1'b1, 2'(m_own)} : 3'b0);
    void'(m_pipe.pop_front());
    if (m_own < 0) begin
      w = pick(r, m_ptr, -1);
      if (w >= 0) begin
        m_own = w;
        m_sel = w;
        m_run = 1;
      end
    end else begin
      mine = r[m_own];
      oth  = (r & ~(4'b0001 << m_own)) != 4'b0;
      lh   = mine && l;
      if (!mine || (m_run >= HOLD_MAX && oth && !lh)) begin
        m_ptr = (m_own + 1) % 4;
        w = pick(r, m_ptr, m_own);
        if (w >= 0) begin
          m_own = w;
          m_sel = w;
          m_run = 1;
        end else begin
          m_own = -1;
        end
      end else if (m_run >= HOLD_MAX) begin
        if (!lh) m_run = 1;
      end else begin
        m_run++;
      end
    end
  endtask

  task automatic step(input bit [3:0] r,
                      input bit rs = 1'b1,
                      input bit l = 1'b0);
    bit lv;
    lv = l;
`ifdef MUX_ARB_LOCK_EN
    bus.lock = l;
`else
    lv = 1'b0;
`endif
    bus.req = r;
    rst_n   = rs;
    @(posedge clk);
    if (!rs) model_reset();
    else     model_edge(r, lv);
    #1;
    chk("gnt", 32'(bus.gnt),
        m_own >= 0 ? 32'(1) << m_own : 32'(0));
    chk("sel", 32'({bus.s0, bus.s1}), 32'(m_sel));
    chk("busy", 32'(bus.busy), 32'(m_own >= 0));
    chk("onehot", 32'($onehot0(bus.gnt)), 32'(1));
    chk("out_vld", 32'(bus.out_vld), 32'(m_pipe[0][2]));
    if (m_pipe[0][2])
      chk("out_id", 32'(bus.out_id), 32'(m_pipe[0][1:0]));
  endtask

  initial begin
    bit [3:0] r;
    bit       rs;
    bit       lk;
    bus.req = '0;
`ifdef MUX_ARB_LOCK_EN
    bus.lock = 1'b0;
`endif
    model_reset();
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    // Single requester latency
    step(4'b0000);
    step(4'b0001);
    repeat (MUX_LAT + 3) step(4'b0001);
    step(4'b0000);
    step(4'b0000);
    // Full contention rotates every HOLD_MAX
    repeat (5 * HOLD_MAX + 4) step(4'b1111);
    // Owner 2 drops with 3 waiting
    step(4'b0000, 1'b0);
    repeat (3) step(4'b0100);
    step(4'b1100);
    repeat (3) step(4'b1000);
    step(4'b1001);
    step(4'b0001);
    // Lone requester never released
    repeat (20) step(4'b0010);
    // Reset mid-grant with tags in flight
    repeat (4) step(4'b0011);
    step(4'b0011, 1'b0);
    repeat (MUX_LAT + 4) step(4'b1111);
`ifdef MUX_ARB_LOCK_EN
    step(4'b0000, 1'b0);
    step(4'b0001);
    repeat (20) step(4'b0011, 1'b1, 1'b1);
    repeat (4) step(4'b0011, 1'b1, 1'b0);
`endif
    r = '0;
    repeat (3000) begin
      if ($urandom_range(3) == 0) r = 4'($urandom);
      rs = ($urandom_range(99) != 0);
      lk = ($urandom_range(3) != 0);
      step(r, rs, lk);
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
